// File: rtl/packer_slot_scheduler_if.sv
// Bus bundle between the slot scheduler and its packer bank / frame FIFO.
// The scheduler takes the master view; the packers, FIFO and control take the slave view.
interface packer_slot_scheduler_if #(
  parameter int NCH = 4,
  parameter int CHW = 2
);
  logic              enable;
  logic              errClear;
  logic [NCH-1:0]    dataRequest;
  logic [12*NCH-1:0] chData;
  logic [NCH-1:0]    chReady;
  logic [11:0]       outData;
  logic [CHW-1:0]    outChan;
  logic              outWrEn;
  logic              frameStart;
  logic [NCH-1:0]    errFlags;
  logic              overrun;

  modport master (
    input  enable, errClear, chData, chReady,
    output dataRequest, outData, outChan, outWrEn, frameStart, errFlags, overrun
  );

  modport slave (
    output enable, errClear, chData, chReady,
    input  dataRequest, outData, outChan, outWrEn, frameStart, errFlags, overrun
  );
endinterface

// File: rtl/packer_slot_scheduler.sv
// Round-robin time-division scheduler: one packer request per fixed slot, word (or zero on
// timeout) written to the frame FIFO tagged with its channel, with sticky error reporting.
module packer_slot_scheduler #(
  parameter int NCH         = 4,
  parameter int CHW         = 2,
  parameter int SLOT_CYCLES = 240,
  parameter int REQ_WIDTH   = 8,
  parameter int TIMEOUT     = 64
) (
  input logic                     clk,
  input logic                     reset,
  packer_slot_scheduler_if.master bus
);
  localparam int TW = $clog2(SLOT_CYCLES);
  localparam int CW = $clog2((REQ_WIDTH > TIMEOUT) ? REQ_WIDTH : TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE} state_e;

  state_e         state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0] ready_prev_q, ready_prev_d;
  logic           got_q, got_d;
  logic [11:0]    cap_q, cap_d;
  logic [NCH-1:0] data_request_q, data_request_d;
  logic [11:0]    out_data_q, out_data_d;
  logic [CHW-1:0] out_chan_q, out_chan_d;
  logic           out_wr_en_q, out_wr_en_d;
  logic           frame_start_q, frame_start_d;
  logic [NCH-1:0] err_flags_q, err_flags_d;
  logic           overrun_q, overrun_d;

  logic [NCH-1:0] ch_onehot;
  logic [11:0]    ch_word;
  logic           rise;

  always_comb begin
    ch_onehot = '0;
    ch_word   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == CHW'(k)) begin
        ch_onehot[k] = 1'b1;
        ch_word      = bus.chData[12*k +: 12];
      end
    end
  end

  // Only the channel being served is edge-detected; other channels' strobes are ignored.
  assign rise = |(ch_onehot & bus.chReady & ~ready_prev_q);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d        = state_q;
    ch_d           = ch_q;
    cnt_d          = cnt_q;
    got_d          = got_q;
    cap_d          = cap_q;
    data_request_d = data_request_q;
    out_data_d     = out_data_q;
    out_chan_d     = out_chan_q;
    out_wr_en_d    = 1'b0;
    frame_start_d  = 1'b0;
    err_flags_d    = err_flags_q;
    overrun_d      = overrun_q;
    ready_prev_d   = bus.chReady;

    if (!bus.enable && state_q == S_IDLE)    timer_d = '0;
    else if (timer_q == TW'(SLOT_CYCLES-1))  timer_d = '0;
    else                                     timer_d = timer_q + 1'b1;

    // Clear first so a set event later in this block wins.
    if (bus.errClear) begin
      err_flags_d = '0;
      overrun_d   = 1'b0;
    end
    if (state_q != S_IDLE && timer_q == '0) overrun_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (!bus.enable) begin
          ch_d = '0;
        end else if (timer_q == '0) begin
          state_d        = S_REQ;
          data_request_d = ch_onehot;
          frame_start_d  = (ch_q == '0);
          cnt_d          = '0;
          got_d          = 1'b0;
        end
      end
      S_REQ: begin
        if (rise && !got_q) begin
          got_d = 1'b1;
          cap_d = ch_word;
        end
        if (cnt_q == CW'(REQ_WIDTH-1)) begin
          data_request_d = '0;
          cnt_d          = '0;
          state_d        = (got_q || rise) ? S_WRITE : S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (rise) begin
          cap_d   = ch_word;
          state_d = S_WRITE;
        end else if (cnt_q == CW'(TIMEOUT-1)) begin
          cap_d       = '0;
          err_flags_d = err_flags_d | ch_onehot;
          state_d     = S_WRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        out_data_d  = cap_q;
        out_chan_d  = ch_q;
        out_wr_en_d = 1'b1;
        ch_d        = (ch_q == CHW'(NCH-1)) ? '0 : ch_q + 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ch_q           <= '0;
      timer_q        <= '0;
      cnt_q          <= '0;
      ready_prev_q   <= '0;
      got_q          <= 1'b0;
      cap_q          <= '0;
      data_request_q <= '0;
      out_data_q     <= '0;
      out_chan_q     <= '0;
      out_wr_en_q    <= 1'b0;
      frame_start_q  <= 1'b0;
      err_flags_q    <= '0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      timer_q        <= timer_d;
      cnt_q          <= cnt_d;
      ready_prev_q   <= ready_prev_d;
      got_q          <= got_d;
      cap_q          <= cap_d;
      data_request_q <= data_request_d;
      out_data_q     <= out_data_d;
      out_chan_q     <= out_chan_d;
      out_wr_en_q    <= out_wr_en_d;
      frame_start_q  <= frame_start_d;
      err_flags_q    <= err_flags_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.dataRequest = data_request_q;
  assign bus.outData     = out_data_q;
  assign bus.outChan     = out_chan_q;
  assign bus.outWrEn     = out_wr_en_q;
  assign bus.frameStart  = frame_start_q;
  assign bus.errFlags    = err_flags_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_packer_slot_scheduler.sv
// Directed bench for packer_slot_scheduler: packer models with programmable ready delay,
// an event monitor, and a second short-slot instance for the overrun case.
module tb_packer_slot_scheduler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  packer_slot_scheduler_if #(.NCH(4), .CHW(2)) bus ();
  packer_slot_scheduler_if #(.NCH(4), .CHW(2)) ov ();

  packer_slot_scheduler #(.NCH(4), .CHW(2)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  packer_slot_scheduler #(.NCH(4), .CHW(2), .SLOT_CYCLES(60)) u_ovr (
    .clk(clk), .reset(reset), .bus(ov)
  );

  logic [3:0] rdy = '0;
  assign bus.chData  = {12'hA03, 12'hA02, 12'hA01, 12'hA00};
  assign bus.chReady = rdy;
  assign ov.chData   = '0;
  assign ov.chReady  = '0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Packer models: ready rises dly[k] cycles after request rise, high for 6 cycles; dly<0 = silent.
  int         dly    [4];
  int         pk_cnt [4];
  bit         pk_act [4];
  logic [3:0] req_prev_m = '0;
  bit         tog3 = 1'b0;
  bit         tog3_prev = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (bus.dataRequest[k] && !req_prev_m[k]) begin
        pk_cnt[k] = 0;
        pk_act[k] = 1'b1;
      end else if (pk_act[k]) begin
        pk_cnt[k]++;
      end
      req_prev_m[k] = bus.dataRequest[k];
      if (pk_act[k] && dly[k] >= 0) begin
        if (pk_cnt[k] == dly[k]) rdy[k] = 1'b1;
        if (pk_cnt[k] == dly[k] + 6) begin
          rdy[k]    = 1'b0;
          pk_act[k] = 1'b0;
        end
      end
    end
    if (tog3) rdy[3] = ~rdy[3];
    else if (tog3_prev) rdy[3] = 1'b0;
    tog3_prev = tog3;
  end

  // Event monitor, sampled 1 time unit after each rising edge.
  typedef struct {
    int          cyc;
    logic [11:0] data;
    logic [1:0]  chan;
  } wr_t;

  wr_t        wr_q [$];
  int         req_start_q [$];
  int         req_len_q [$];
  int         frame_q [$];
  int         rise_cnt [4];
  int         rise_cyc [4];
  int         cyc = 0;
  int         cur_start = 0;
  int         onehot_viol = 0;
  logic [3:0] dr_prev = '0;

  always begin
    wr_t w;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.outWrEn === 1'b1) begin
      w.cyc  = cyc;
      w.data = bus.outData;
      w.chan = bus.outChan;
      wr_q.push_back(w);
    end
    if (bus.frameStart === 1'b1) frame_q.push_back(cyc);
    if ($countones(bus.dataRequest) > 1) onehot_viol++;
    for (int k = 0; k < 4; k++) begin
      if (bus.dataRequest[k] && !dr_prev[k]) begin
        rise_cnt[k]++;
        rise_cyc[k] = cyc;
        cur_start   = cyc;
      end
    end
    if (dr_prev != '0 && bus.dataRequest == '0) begin
      req_start_q.push_back(cur_start);
      req_len_q.push_back(cyc - cur_start);
    end
    dr_prev = bus.dataRequest;
  end

  task automatic wait_wr(input int n, input int budget);
    int i = 0;
    while (wr_q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check($sformatf("wait_wr_%0d", n), 32'(wr_q.size() >= n), 1);
  endtask

  task automatic wait_rise(input int ch, input int budget);
    int rc = rise_cnt[ch];
    int i  = 0;
    while (rise_cnt[ch] == rc && i < budget) begin
      @(negedge clk);
      i++;
    end
    check($sformatf("wait_rise_ch%0d", ch), 32'(rise_cnt[ch] != rc), 1);
  endtask

  task automatic pulse_clear();
    bus.errClear = 1'b1;
    @(negedge clk);
    bus.errClear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n0;
    int rises;
    int frames;
    int ovr_first;
    int wr_first;
    int req1_first;
    int mid_reqs;
    logic [11:0] wr_data;

    for (int k = 0; k < 4; k++) dly[k] = 40;
    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.errClear = 1'b0;
    ov.enable    = 1'b0;
    ov.errClear  = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_dataRequest", 32'(bus.dataRequest), 0);
    check("rst_outData",     32'(bus.outData), 0);
    check("rst_outChan",     32'(bus.outChan), 0);
    check("rst_outWrEn",     32'(bus.outWrEn), 0);
    check("rst_frameStart",  32'(bus.frameStart), 0);
    check("rst_errFlags",    32'(bus.errFlags), 0);
    check("rst_overrun",     32'(bus.overrun), 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic round-robin
    bus.enable = 1'b1;
    wait_wr(4, 2000);
    dly[2] = -1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("basic_data%0d", k), 32'(wr_q[k].data), 32'h0A00 + k);
      check($sformatf("basic_chan%0d", k), 32'(wr_q[k].chan), k);
      check($sformatf("basic_reqlen%0d", k), req_len_q[k], 8);
      if (k > 0) check($sformatf("basic_spacing%0d", k), wr_q[k].cyc - wr_q[k-1].cyc, 240);
    end
    check("basic_latency", wr_q[0].cyc - req_start_q[0], 42);
    wait_wr(5, 2000);
    check("frame_at_req0", frame_q[0], req_start_q[0]);
    check("frame_period", frame_q[1] - frame_q[0], 960);

    // Timeout on channel 2
    wait_wr(8, 2000);
    check("to_data", 32'(wr_q[6].data), 0);
    check("to_chan", 32'(wr_q[6].chan), 2);
    check("to_latency", wr_q[6].cyc - req_start_q[6], 73);
    check("to_errFlags", 32'(bus.errFlags), 32'b0100);
    check("to_ch3_sched", req_start_q[7] - req_start_q[6], 240);
    check("to_ch3_data", 32'(wr_q[7].data), 32'hA03);

    // Sticky / clear
    pulse_clear();
    check("clr_errFlags", 32'(bus.errFlags), 0);
    wait_wr(11, 2000);
    check("resticky_errFlags", 32'(bus.errFlags), 32'b0100);
    pulse_clear();
    check("clr2_errFlags", 32'(bus.errFlags), 0);
    wait_rise(2, 2000);
    repeat (71) @(negedge clk);
    check("coinc_before", 32'(bus.errFlags), 0);
    bus.errClear = 1'b1;
    @(negedge clk);
    bus.errClear = 1'b0;
    @(negedge clk);
    check("coinc_set_wins", 32'(bus.errFlags), 32'b0100);

    // Early ready on ch1, foreign ready toggling on ch3
    dly[1] = 3;
    dly[2] = 40;
    wait_rise(1, 2000);
    tog3 = 1'b1;
    n0 = wr_q.size();
    wait_wr(n0 + 1, 500);
    check("early_chan", 32'(wr_q[n0].chan), 1);
    check("early_data", 32'(wr_q[n0].data), 32'hA01);
    check("early_latency", wr_q[n0].cyc - rise_cyc[1], 9);
    repeat (100) @(negedge clk);
    tog3 = 1'b0;
    wait_rise(2, 2000);
    check("foreign_no_write", wr_q.size(), n0 + 1);

    // Enable stop / restart
    dly[1] = 40;
    wait_rise(1, 2000);
    repeat (5) @(negedge clk);
    bus.enable = 1'b0;
    n0 = wr_q.size();
    wait_wr(n0 + 1, 500);
    wr_data = wr_q[n0].data;
    check("stop_chan", 32'(wr_q[n0].chan), 1);
    check("stop_data", 32'(wr_data), 32'hA01);
    rises  = rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3];
    frames = frame_q.size();
    repeat (600) @(negedge clk);
    check("stop_no_req", rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3], rises);
    check("stop_no_frame", frame_q.size(), frames);
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    check("restart_req", 32'(bus.dataRequest), 32'b0001);
    check("restart_frame", 32'(bus.frameStart), 1);

    // Reset during WAIT
    repeat (20) @(negedge clk);
    reset      = 1'b1;
    bus.enable = 1'b0;
    #1;
    check("rstmid_dataRequest", 32'(bus.dataRequest), 0);
    check("rstmid_outData",     32'(bus.outData), 0);
    check("rstmid_outChan",     32'(bus.outChan), 0);
    check("rstmid_outWrEn",     32'(bus.outWrEn), 0);
    check("rstmid_errFlags",    32'(bus.errFlags), 0);
    check("rstmid_overrun",     32'(bus.overrun), 0);
    n0 = wr_q.size();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    check("rstmid_no_write", wr_q.size(), n0);

    // Overrun with a 60-cycle slot and a silent packer
    ovr_first  = -1;
    wr_first   = -1;
    req1_first = -1;
    mid_reqs   = 0;
    wr_data    = 12'hFFF;
    ov.enable  = 1'b1;
    for (int i = 1; i <= 130; i++) begin
      @(posedge clk);
      #1;
      if (ov.overrun && ovr_first < 0) ovr_first = i;
      if (ov.outWrEn && wr_first < 0) begin
        wr_first = i;
        wr_data  = ov.outData;
      end
      if (ov.dataRequest[1] && req1_first < 0) req1_first = i;
      if (i >= 9 && i <= 120 && ov.dataRequest != '0) mid_reqs++;
    end
    check("ovr_set_cycle", ovr_first, 61);
    check("ovr_write_cycle", wr_first, 74);
    check("ovr_write_data", 32'(wr_data), 0);
    check("ovr_no_mid_req", mid_reqs, 0);
    check("ovr_deferred_req", req1_first, 121);
    check("ovr_sticky", 32'(ov.overrun), 1);

    check("req_onehot", onehot_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
